gather_mux: RTL and testbench
=============================

# gather_mux

Eight-to-one gathering multiplexer with round-robin arbitration and a registered valid/ready output stage. It collects bytes from eight producer lanes onto a single consumer bus and tags each byte with its source index, performing the inverse of the processor's select-driven 1-to-8 byte distribution. It sits on the Processor_v3 datapath wherever several units write back to one shared destination.

## Interface
- WIDTH, 8, data width of every lane and of the output.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in0 … data_in7  input  WIDTH each  producer lane data.
- in_valid  input  8  bit i: lane i holds a byte.
- in_ready  output  8  bit i: lane i's byte is taken this cycle.
- data_out  output  WIDTH  registered output byte.
- out_sel  output  3  source lane of data_out.
- out_valid  output  1  data_out/out_sel hold an untaken byte.
- out_ready  input  1  consumer accepts the byte this cycle.
- xfer_count  output  16  number of output handshakes completed, wrapping.

## Operation
- Output stage: one entry holding data_out, out_sel and out_valid. No further buffering.
- can_load = !out_valid || out_ready.
- Priority pointer ptr (3 bits, reset 0). Grant g = first lane in order ptr, ptr+1, …, ptr+7 (mod 8) with in_valid set.
- in_ready is one-hot or zero:
  - in_ready[g] = can_load when any in_valid bit is set.
  - All other bits are 0.
  - in_ready is combinational from in_valid, out_valid and out_ready.
- Producers must not make in_valid depend on in_ready. A producer holds its data stable while in_valid=1 && in_ready=0.
- On a lane transfer (in_valid[g] && in_ready[g]):
  - data_out ← data_in_g, out_sel ← g, out_valid ← 1.
  - ptr ← g+1 (mod 8; lane 7 wraps to 0).
- When out_valid && out_ready and no lane transfers that cycle: out_valid ← 0. data_out and out_sel keep their last value.
- When out_valid && out_ready, xfer_count increments. 0xFFFF wraps to 0x0000.
- Simultaneous drain and load: the old byte is consumed and the new byte is loaded in the same edge, so out_valid stays 1.
- With out_valid=1 && out_ready=0:
  - in_ready = 0.
  - The output register, ptr and xfer_count all hold.
- When all in_valid bits are 0, ptr does not move.

## Timing
- Reset (asynchronous, takes effect immediately while rst_n=0):
  - data_out=0, out_sel=0, out_valid=0, xfer_count=0, ptr=0.
  - in_ready=0 because it is gated by rst_n.
- Latency: 1 cycle. A byte accepted at edge k is visible on data_out after edge k, with out_valid=1.
- Throughput: 1 byte/cycle while out_ready=1 and any lane is valid.
- Fairness: with all eight lanes continuously valid and out_ready=1, grants go 0,1,2,…,7,0,…. Each lane waits at most 7 grants.
- Reset asserted mid-transfer: the byte in the output register is dropped. ptr returns to 0, so lane 0 has priority on the first cycle after release.
- The first edge after rst_n deasserts may already perform a transfer.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 → out_valid, data_out, out_sel, xfer_count and in_ready go to 0 immediately, without waiting for a clock edge.
- Single lane:
  - Stimulus: in_valid=8'b0000_1000, data_in3=8'hA5, out_ready=1.
  - Response: in_ready=8'b0000_1000. The next cycle shows data_out=8'hA5, out_sel=3, out_valid=1. xfer_count=1 one cycle after that.
- Round-robin:
  - Stimulus: all lanes valid, data_in_i=8'h10+i, out_ready=1 for 10 cycles.
  - Response: out_sel sequence 0,1,…,7,0,1. data_out matches the lane. Exactly one in_ready bit per cycle.
- Backpressure:
  - Stimulus: lanes 2 and 5 valid, out_ready=0 for 4 cycles after the first load.
  - Response: data_out and out_sel=2 hold, in_ready=0, ptr=3.
  - After out_ready=1: lane 5 is loaded on the same edge that drains lane 2. out_valid never drops.
- Pointer wrap:
  - Stimulus: ptr=7 after a lane 6 grant; lanes 0 and 7 valid.
  - Response: lane 7 is granted first, then lane 0.
- Counter wrap: preload by 65535 handshakes (or a forced value of 0xFFFF), then one handshake → xfer_count=0x0000.

Source files
------------

// File: rtl/gather_mux.sv
// gather_mux: eight producer lanes gathered onto one byte bus through a
// round-robin arbiter and a single registered valid/ready output entry.
// Each output byte carries the index of the lane it came from.
module gather_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic [WIDTH-1:0] data_in4,
  input  logic [WIDTH-1:0] data_in5,
  input  logic [WIDTH-1:0] data_in6,
  input  logic [WIDTH-1:0] data_in7,
  input  logic [7:0]       in_valid,
  output logic [7:0]       in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [2:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      xfer_count
);

  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
  logic [2:0] ptr;
  logic [2:0] grant;
  logic [2:0] idx;
  logic       found;
  logic       can_load;
  logic       take;
  logic       drain;

  assign lane_data = {data_in7, data_in6, data_in5, data_in4,
                      data_in3, data_in2, data_in1, data_in0};

  // Round-robin search: first valid lane starting at ptr, wrapping mod 8.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ptr + 3'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // The entry can accept a byte when empty or being drained this cycle.
  // rst_n gating keeps in_ready low while reset is held.
  assign can_load = !out_valid || out_ready;
  assign take     = rst_n && found && can_load;
  assign drain    = out_valid && out_ready;
  assign in_ready = take ? (8'b1 << grant) : 8'b0;

  // Output entry and priority pointer; a load wins over a drain so a
  // simultaneous drain+load keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (take) begin
      data_out  <= lane_data[grant];
      out_sel   <= grant;
      out_valid <= 1'b1;
      ptr       <= grant + 3'd1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_count <= '0;
    else if (drain) xfer_count <= xfer_count + 16'd1;
  end

endmodule

// File: tb/tb_gather_mux.sv
// Bench for gather_mux: behavioural model (round-robin scan by modular
// arithmetic over an array of lanes) compared against the DUT every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_gather_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din [8];
  logic [7:0] inv;
  logic [7:0] in_ready;
  logic [7:0] data_out;
  logic [2:0] out_sel;
  logic       out_valid;
  logic       oready;
  logic [15:0] xfer_count;

  int compared = 0;
  int mismatched = 0;

  // behavioural model state
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_ptr;
  int       m_cnt;

  always #5 clk = ~clk;

  gather_mux #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .in_valid(inv), .in_ready(in_ready),
    .data_out(data_out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(oready), .xfer_count(xfer_count)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock: inputs are already driven; check in_ready, clock, advance
  // the model and check the registered outputs.
  task automatic step();
    bit any;
    bit can;
    int g;
    int exp_rdy;
    #1;
    any = 0; g = 0;
    for (int i = 0; i < 8; i++)
      if (!any && inv[(m_ptr + i) % 8]) begin any = 1; g = (m_ptr + i) % 8; end
    can = !m_valid || oready;
    exp_rdy = (any && can) ? (1 << g) : 0;
    check("in_ready", int'(in_ready), exp_rdy);
    @(posedge clk); #1;
    if (m_valid && oready) m_cnt = (m_cnt + 1) % 65536;
    if (any && can) begin
      m_data = din[g]; m_sel = g; m_valid = 1; m_ptr = (g + 1) % 8;
    end else if (m_valid && oready) m_valid = 0;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("data_out", int'(data_out), m_data);
    check("out_sel", int'(out_sel), m_sel);
    check("xfer_count", int'(xfer_count), m_cnt);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; inv = '0; oready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    model_reset();
    #12;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 0);
    check("rst xfer_count", int'(xfer_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single lane
    inv = 8'h08; din[3] = 8'hA5; oready = 1'b1;
    #1 check("single in_ready", int'(in_ready), 8'h08);
    step();
    check("single data_out", int'(data_out), 8'hA5);
    check("single out_sel", int'(out_sel), 3);
    check("single out_valid", int'(out_valid), 1);
    inv = 8'h00;
    step();
    check("single xfer_count", int'(xfer_count), 1);

    // reset mid-stream with a byte held in the output entry
    inv = 8'h08; din[3] = 8'h5A; oready = 1'b0;
    step();
    check("pre-rst out_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst data_out", int'(data_out), 0);
    check("midrst out_sel", int'(out_sel), 0);
    check("midrst xfer_count", int'(xfer_count), 0);
    check("midrst in_ready", int'(in_ready), 0);
    model_reset();
    #1 rst_n = 1'b1;

    // round-robin: all lanes valid for 10 cycles
    inv = 8'hFF; oready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 8'(8'h10 + i);
    for (int k = 0; k < 10; k++) begin
      step();
      check("rr out_sel", int'(out_sel), k % 8);
      check("rr data_out", int'(data_out), 8'h10 + (k % 8));
    end

    // backpressure: lanes 2 and 5 (pointer is 2 after the last grant of 1)
    inv = 8'h00;
    step();
    inv = 8'h24; din[2] = 8'hC2; din[5] = 8'hC5;
    step();
    check("bp first sel", int'(out_sel), 2);
    inv = 8'h20; oready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("bp in_ready", int'(in_ready), 0);
      step();
      check("bp hold sel", int'(out_sel), 2);
      check("bp hold data", int'(data_out), 8'hC2);
      check("bp hold valid", int'(out_valid), 1);
    end
    oready = 1'b1;
    step();
    check("bp reload sel", int'(out_sel), 5);
    check("bp reload valid", int'(out_valid), 1);

    // pointer wrap: lane 6 grant leaves ptr at 7
    inv = 8'h40; din[6] = 8'h66;
    step();
    inv = 8'h81; din[7] = 8'h77; din[0] = 8'h70;
    step();
    check("wrap first", int'(out_sel), 7);
    inv = 8'h01;
    step();
    check("wrap second", int'(out_sel), 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      inv = 8'($urandom);
      if ($urandom_range(3) == 0) inv = 8'h00;
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
      oready = ($urandom_range(3) != 0);
      step();
    end

    // counter wrap: stream handshakes until the count reaches 0xFFFF
    inv = 8'hFF; oready = 1'b1;
    guard = 0;
    while (m_cnt != 65535 && guard < 70000) begin
      step();
      guard++;
    end
    check("cnt preload", int'(xfer_count), 16'hFFFF);
    step();
    check("cnt wrap", int'(xfer_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
